ps2_scancode_decoder: RTL and testbench

//   Converts the raw PS/2 set-2 scan-code byte stream into key events.

---
 rtl/ps2_scancode_decoder.sv | 167 ++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 set-2 scan-code decoder: folds E0/F0 prefixes into make/break events,
// tracks the currently held key and queues events in a small FIFO.
module ps2_scancode_decoder #(
  parameter int DEPTH     = 8,
  parameter int TIMEOUT   = 1250000,
  parameter bit REPEAT_EN = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     scan_valid,
  input  logic [7:0]               scan_byte,
  output logic [31:0]              keyb_char,
  output logic                     evt_valid,
  output logic [9:0]               evt_data,
  input  logic                     evt_pop,
  output logic [$clog2(DEPTH):0]   evt_count,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic [8:0]      held_q, held_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            valid_q, valid_d;
  logic [9:0]      head_q, head_d;
  logic            ovf_q, ovf_d;
  logic [9:0]      mem_q [DEPTH];

  logic            evt_make, evt_break, evt_ext;
  logic [8:0]      evt_key;
  logic            push_req, do_push, do_pop;
  logic [9:0]      push_data;
  logic            filtered;

  assign filtered = (scan_byte == 8'h00) || (scan_byte == 8'hAA) || (scan_byte == 8'hEE) ||
                    (scan_byte == 8'hFA) || (scan_byte == 8'hFE) || (scan_byte == 8'hFF);

  // Prefix FSM and abandon timer.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, otherwise
    // paths that skip an assignment infer a latch.
    state_d   = state_q;
    tmo_d     = tmo_q;
    evt_make  = 1'b0;
    evt_break = 1'b0;
    evt_ext   = 1'b0;
    if (scan_valid) begin
      tmo_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (scan_byte == 8'hE0)      state_d = S_EXT;
          else if (scan_byte == 8'hF0) state_d = S_BRK;
          else if (!filtered)          evt_make = 1'b1;
        end
        S_EXT: begin
          if (scan_byte == 8'hE0)      state_d = S_EXT;
          else if (scan_byte == 8'hF0) state_d = S_EXT_BRK;
          else begin
            evt_make = 1'b1;
            evt_ext  = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_BRK: begin
          if (scan_byte == 8'hF0)      state_d = S_BRK;
          else if (scan_byte == 8'hE0) state_d = S_EXT_BRK;
          else begin
            evt_break = 1'b1;
            state_d   = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (scan_byte != 8'hE0 && scan_byte != 8'hF0) begin
            evt_break = 1'b1;
            evt_ext   = 1'b1;
            state_d   = S_IDLE;
          end
        end
      endcase
    end else if (state_q == S_IDLE) begin
      tmo_d = '0;
    end else if (tmo_q == TW'(TIMEOUT - 1)) begin
      state_d = S_IDLE;
      tmo_d   = '0;
    end else begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  // Held-key tracking and FIFO push request.
  always_comb begin
    evt_key   = {evt_ext, scan_byte};
    held_d    = held_q;
    push_req  = 1'b0;
    push_data = {evt_break, evt_key};
    if (evt_make) begin
      held_d   = evt_key;
      push_req = REPEAT_EN || (evt_key != held_q);
    end
    if (evt_break) begin
      push_req = 1'b1;
      if (evt_key == held_q) held_d = '0;
    end
  end

  // FIFO bookkeeping; a full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    logic [PW-1:0] next_rd;
    do_pop   = evt_pop && (count_q != '0);
    do_push  = push_req && ((count_q != CW'(DEPTH)) || do_pop);
    ovf_d    = ovf_q || (push_req && !do_push);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    next_rd  = do_pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_ptr_d = next_rd;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
    valid_d  = (count_d != '0);
    if (count_d == '0)                        head_d = '0;
    else if (do_push && next_rd == wr_ptr_q) head_d = push_data;
    else                                      head_d = mem_q[next_rd];
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (reset) begin
      state_q  <= S_IDLE;
      tmo_q    <= '0;
      held_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      head_q   <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      tmo_q    <= tmo_d;
      held_q   <= held_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      head_q   <= head_d;
      ovf_q    <= ovf_d;
    end
  end

  // NOTE: the storage array is not reset; entries are only read once the
  // count marks them as written, so a reset would cost area for nothing.
  always_ff @(posedge clk) begin
    if (!reset && do_push) mem_q[wr_ptr_q] <= push_data;
  end

  assign keyb_char = {23'b0, held_q};
  assign evt_valid = valid_q;
  assign evt_data  = head_q;
  assign evt_count = count_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed bench for ps2_scancode_decoder: one instance with typematic repeats
// queued, one with them suppressed, both fed the same byte stream.
module tb_ps2_scancode_decoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        scan_valid;
  logic [7:0]  scan_byte;
  logic        evt_pop;

  logic [31:0] keyb_char, nr_keyb_char;
  logic        evt_valid, nr_evt_valid;
  logic [9:0]  evt_data, nr_evt_data;
  logic [3:0]  evt_count, nr_evt_count;
  logic        overflow, nr_overflow;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_scancode_decoder #(.DEPTH(8), .TIMEOUT(16), .REPEAT_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_byte(scan_byte),
    .keyb_char(keyb_char), .evt_valid(evt_valid), .evt_data(evt_data),
    .evt_pop(evt_pop), .evt_count(evt_count), .overflow(overflow)
  );

  ps2_scancode_decoder #(.DEPTH(8), .TIMEOUT(16), .REPEAT_EN(1'b0)) dut_nr (
    .clk(clk), .reset(reset), .scan_valid(scan_valid), .scan_byte(scan_byte),
    .keyb_char(nr_keyb_char), .evt_valid(nr_evt_valid), .evt_data(nr_evt_data),
    .evt_pop(evt_pop), .evt_count(nr_evt_count), .overflow(nr_overflow)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic send(input logic [7:0] b, input logic pop = 1'b0);
    scan_byte  = b;
    scan_valid = 1'b1;
    evt_pop    = pop;
    @(negedge clk);
    scan_valid = 1'b0;
    evt_pop    = 1'b0;
  endtask

  task automatic pop_one();
    evt_pop = 1'b1;
    @(negedge clk);
    evt_pop = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; scan_valid = 1'b0; scan_byte = 8'h00; evt_pop = 1'b0;
    idle(2);
    reset = 1'b0;

    // 1: reset state, make then break of 1C.
    check("rst_keyb", keyb_char, 32'h0);
    check("rst_valid", evt_valid, 1'b0);
    check("rst_data", evt_data, 10'h0);
    check("rst_count", evt_count, 4'd0);
    check("rst_ovf", overflow, 1'b0);
    send(8'h1C);
    check("t1_keyb_make", keyb_char, 32'h01C);
    check("t1_valid", evt_valid, 1'b1);
    check("t1_data", evt_data, 10'h01C);
    check("t1_count", evt_count, 4'd1);
    send(8'hF0);
    check("t1_keyb_prefix", keyb_char, 32'h01C);
    send(8'h1C);
    check("t1_keyb_brk", keyb_char, 32'h0);
    check("t1_count2", evt_count, 4'd2);
    check("t1_head_kept", evt_data, 10'h01C);
    pop_one();
    check("t1_data2", evt_data, 10'h21C);
    check("t1_count3", evt_count, 4'd1);

    // 2: extended make/break, break of another key leaves held key alone.
    do_reset();
    send(8'hE0); send(8'h75);
    check("t2_keyb_ext", keyb_char, 32'h175);
    check("t2_data_ext", evt_data, 10'h175);
    send(8'hF0); send(8'h1C);
    check("t2_keyb_other_brk", keyb_char, 32'h175);
    send(8'hE0); send(8'hF0); send(8'h75);
    check("t2_keyb_ext_brk", keyb_char, 32'h0);
    check("t2_count", evt_count, 4'd3);
    pop_one();
    check("t2_data_brk1c", evt_data, 10'h21C);
    pop_one();
    check("t2_data_extbrk", evt_data, 10'h375);

    // 3: filtered bytes in IDLE, but not after a prefix.
    do_reset();
    send(8'hAA); send(8'hFA); send(8'h00);
    check("t3_count_filt", evt_count, 4'd0);
    check("t3_valid_filt", evt_valid, 1'b0);
    send(8'hF0); send(8'hAA);
    check("t3_count_brk", evt_count, 4'd1);
    check("t3_data_brk", evt_data, 10'h2AA);

    // 4: dangling prefix abandoned after TIMEOUT idle cycles only.
    do_reset();
    send(8'hE0); idle(14); send(8'h1C);
    check("t4_no_timeout", evt_data, 10'h11C);
    do_reset();
    send(8'hE0); idle(16); send(8'h1C);
    check("t4_timeout_data", evt_data, 10'h01C);
    check("t4_timeout_keyb", keyb_char, 32'h01C);
    do_reset();
    send(8'hE0); idle(10); send(8'hF0); idle(10); send(8'h1C);
    check("t4_restart", evt_data, 10'h31C);

    // 5: overflow, push+pop when full, drain, push into empty with pop.
    do_reset();
    for (int i = 0; i < 9; i++) send(8'h10 + 8'(i));
    check("t5_count_full", evt_count, 4'd8);
    check("t5_ovf", overflow, 1'b1);
    check("t5_head", evt_data, 10'h010);
    check("t5_keyb_dropped", keyb_char, 32'h018);
    send(8'h20, 1'b1);
    check("t5_count_pp", evt_count, 4'd8);
    check("t5_head_pp", evt_data, 10'h011);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t5_drain%0d", i), evt_data, (i < 7) ? 32'h011 + 32'(i) : 32'h020);
      pop_one();
    end
    check("t5_valid_empty", evt_valid, 1'b0);
    check("t5_count_empty", evt_count, 4'd0);
    pop_one();
    check("t5_extra_pop", evt_count, 4'd0);
    check("t5_ovf_sticky", overflow, 1'b1);
    send(8'h22, 1'b1);
    check("t5_push_pop_empty", evt_count, 4'd1);
    check("t5_push_pop_data", evt_data, 10'h022);

    // 6: typematic suppression, and reset beating simultaneous inputs.
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C);
    check("t6_rep_count", evt_count, 4'd3);
    check("t6_norep_count", nr_evt_count, 4'd1);
    check("t6_norep_keyb", nr_keyb_char, 32'h01C);
    check("t6_norep_data", nr_evt_data, 10'h01C);
    check("t6_norep_valid", nr_evt_valid, 1'b1);
    check("t6_norep_ovf", nr_overflow, 1'b0);
    send(8'hE0);
    reset = 1'b1; scan_valid = 1'b1; scan_byte = 8'h1C; evt_pop = 1'b1;
    @(negedge clk);
    reset = 1'b0; scan_valid = 1'b0; evt_pop = 1'b0;
    check("t6_rst_keyb", keyb_char, 32'h0);
    check("t6_rst_count", evt_count, 4'd0);
    send(8'h1C);
    check("t6_after_rst", evt_data, 10'h01C);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
